// File: rtl/svm_pkg.sv
// Shared types and helpers for the SVM classification pipeline.
// KER_W/TERM_W describe the default 9-bit configuration; modules derive their own widths.
package svm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef enum logic {K_LINEAR, K_POLY2} kmode_t;

    localparam int unsigned DEF_DATA_W  = 9;
    localparam int unsigned DEF_ALPHA_W = 9;
    localparam int unsigned KER_W       = 4 * DEF_DATA_W + 2;
    localparam int unsigned TERM_W      = KER_W + DEF_ALPHA_W;
    localparam int unsigned WIDE_W      = 128;

    // Operands are sign-extended to WIDE_W so the sum is exact; the result is clamped
    // to the signed acc_w range and returned sign-extended.
    function automatic logic signed [WIDE_W-1:0] sat_add(
        input logic signed [WIDE_W-1:0] a,
        input logic signed [WIDE_W-1:0] b,
        input int unsigned              acc_w
    );
        logic signed [WIDE_W-1:0] one;
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        logic signed [WIDE_W-1:0] s;
        one = {{(WIDE_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (acc_w - 1)) - one;
        lo  = -hi - one;
        s   = a + b;
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/svm_kernel_unit.sv
// Stage 1: registered kernel K = x_test*sv_x + 1, optionally squared, plus beat side data.
module svm_kernel_unit
    import svm_pkg::*;
#(
    parameter int unsigned DATA_W  = 9,
    parameter int unsigned ALPHA_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  kernel_mode,
    input  logic [DATA_W-1:0]     x_test,
    input  logic [DATA_W-1:0]     sv_x,
    input  logic [ALPHA_W-1:0]    sv_alpha,
    input  logic signed [1:0]     sv_y,
    output logic                  out_valid,
    output logic [4*DATA_W+1:0]   kernel,
    output logic [ALPHA_W-1:0]    alpha,
    output logic                  neg,
    output logic                  zero
);

    localparam int unsigned P_W = 2 * DATA_W;
    localparam int unsigned KW  = 4 * DATA_W + 2;

    logic [P_W-1:0] prod;
    logic [P_W:0]   p1;
    logic [KW-1:0]  k_d;

    always_comb begin
        prod = P_W'(x_test) * P_W'(sv_x);
        p1   = {1'b0, prod} + {{P_W{1'b0}}, 1'b1};
        if (kernel_mode == K_POLY2) begin
            k_d = KW'(p1) * KW'(p1);
        end else begin
            k_d = KW'(p1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            kernel    <= '0;
            alpha     <= '0;
            neg       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                kernel <= k_d;
                alpha  <= sv_alpha;
                // -2 has the sign bit set, so it is treated as -1
                neg    <= sv_y[1];
                zero   <= (sv_y == 2'sb00);
            end
        end
    end

endmodule

// File: rtl/svm_classifier_pipe.sv
// Scores one test sample against a stream of NUM_SV support vectors and returns a +/-1 class
// together with the saturated decision score.
module svm_classifier_pipe
    import svm_pkg::*;
#(
    parameter int unsigned DATA_W  = 9,
    parameter int unsigned ALPHA_W = 9,
    parameter int unsigned NUM_SV  = 100,
    parameter int unsigned ACC_W   = 56
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_W-1:0]       x_test,
    input  logic                    kernel_mode,
    input  logic signed [ACC_W-1:0] bias,
    input  logic                    sv_valid,
    output logic                    sv_ready,
    input  logic [ALPHA_W-1:0]      sv_alpha,
    input  logic [DATA_W-1:0]       sv_x,
    input  logic signed [1:0]       sv_y,
    output logic                    busy,
    output logic                    result_valid,
    output logic signed [1:0]       class_out,
    output logic signed [ACC_W-1:0] score
);

    localparam int unsigned KW    = 4 * DATA_W + 2;
    localparam int unsigned TW    = KW + ALPHA_W;
    localparam int unsigned CNT_W = (NUM_SV < 2) ? 1 : $clog2(NUM_SV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SV - 1);

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [DATA_W-1:0]       x_q;
    logic                    mode_q;
    logic signed [ACC_W-1:0] bias_q;
    logic signed [ACC_W-1:0] acc;
    logic                    drain_cnt;

    logic                    accept;
    logic                    k_valid;
    logic [KW-1:0]           k_ker;
    logic [ALPHA_W-1:0]      k_alpha;
    logic                    k_neg;
    logic                    k_zero;
    logic [TW-1:0]           mag;
    logic signed [WIDE_W-1:0] term;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] score_d;

    assign accept = sv_valid && sv_ready;
    assign busy   = (state != IDLE);

    svm_kernel_unit #(
        .DATA_W  (DATA_W),
        .ALPHA_W (ALPHA_W)
    ) u_kernel (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (accept),
        .kernel_mode (mode_q),
        .x_test      (x_q),
        .sv_x        (sv_x),
        .sv_alpha    (sv_alpha),
        .sv_y        (sv_y),
        .out_valid   (k_valid),
        .kernel      (k_ker),
        .alpha       (k_alpha),
        .neg         (k_neg),
        .zero        (k_zero)
    );

    always_comb begin
        mag  = TW'(k_alpha) * TW'(k_ker);
        term = WIDE_W'(mag);
        if (k_zero) begin
            term = '0;
        end else if (k_neg) begin
            term = -term;
        end
        acc_d   = ACC_W'(sat_add(WIDE_W'(acc), term, ACC_W));
        score_d = ACC_W'(sat_add(WIDE_W'(acc), WIDE_W'(bias_q), ACC_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            x_q          <= '0;
            mode_q       <= 1'b0;
            bias_q       <= '0;
            acc          <= '0;
            drain_cnt    <= 1'b0;
            sv_ready     <= 1'b0;
            result_valid <= 1'b0;
            class_out    <= 2'sb00;
            score        <= '0;
        end else begin
            result_valid <= 1'b0;
            if (k_valid) begin
                acc <= acc_d;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_q      <= x_test;
                        mode_q   <= kernel_mode;
                        bias_q   <= bias;
                        acc      <= '0;
                        count    <= '0;
                        sv_ready <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        count <= count + CNT_W'(1);
                        if (count == LAST) begin
                            sv_ready  <= 1'b0;
                            drain_cnt <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Second drain cycle: the last term landed in acc on the previous edge
                    if (drain_cnt) begin
                        score        <= score_d;
                        class_out    <= (score_d > 0) ? 2'sb01 : 2'sb11;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_svm_classifier_pipe.sv
// Randomised self-checking bench: three DUT configurations scored against an arithmetic model.
module tb_svm_classifier_pipe;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [2:0]          start_v = '0;
    logic [8:0]          x_test = '0;
    logic                kernel_mode = 1'b0;
    logic signed [55:0]  bias = '0;
    logic                sv_valid = 1'b0;
    logic [8:0]          sv_alpha = '0;
    logic [8:0]          sv_x = '0;
    logic signed [1:0]   sv_y = '0;

    logic                rdy_a, rdy_b, rdy_c;
    logic                busy_a, busy_b, busy_c;
    logic                rv_a, rv_b, rv_c;
    logic signed [1:0]   cls_a, cls_b, cls_c;
    logic signed [55:0]  score_a, score_b;
    logic signed [15:0]  score_c;

    int                  sel = 0;
    logic                rdy_m, busy_m, rv_m;
    logic signed [1:0]   cls_m;
    logic signed [55:0]  sc_m;

    int                  n_checks = 0;
    int                  n_pass = 0;
    int                  b_alpha[8];
    int                  b_x[8];
    int                  b_y[8];

    always #5 clk = ~clk;

    svm_classifier_pipe #(.DATA_W(9), .ALPHA_W(9), .NUM_SV(4), .ACC_W(56)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .x_test(x_test),
        .kernel_mode(kernel_mode), .bias(bias), .sv_valid(sv_valid), .sv_ready(rdy_a),
        .sv_alpha(sv_alpha), .sv_x(sv_x), .sv_y(sv_y), .busy(busy_a),
        .result_valid(rv_a), .class_out(cls_a), .score(score_a)
    );

    svm_classifier_pipe #(.DATA_W(9), .ALPHA_W(9), .NUM_SV(5), .ACC_W(56)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .x_test(x_test),
        .kernel_mode(kernel_mode), .bias(bias), .sv_valid(sv_valid), .sv_ready(rdy_b),
        .sv_alpha(sv_alpha), .sv_x(sv_x), .sv_y(sv_y), .busy(busy_b),
        .result_valid(rv_b), .class_out(cls_b), .score(score_b)
    );

    svm_classifier_pipe #(.DATA_W(9), .ALPHA_W(9), .NUM_SV(4), .ACC_W(16)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .x_test(x_test),
        .kernel_mode(kernel_mode), .bias(bias[15:0]), .sv_valid(sv_valid), .sv_ready(rdy_c),
        .sv_alpha(sv_alpha), .sv_x(sv_x), .sv_y(sv_y), .busy(busy_c),
        .result_valid(rv_c), .class_out(cls_c), .score(score_c)
    );

    always_comb begin
        rdy_m  = rdy_a;
        busy_m = busy_a;
        rv_m   = rv_a;
        cls_m  = cls_a;
        sc_m   = score_a;
        if (sel == 1) begin
            rdy_m  = rdy_b;
            busy_m = busy_b;
            rv_m   = rv_b;
            cls_m  = cls_b;
            sc_m   = score_b;
        end else if (sel == 2) begin
            rdy_m  = rdy_c;
            busy_m = busy_c;
            rv_m   = rv_c;
            cls_m  = cls_c;
            sc_m   = 56'(score_c);
        end
    end

    function automatic longint clamp(input longint v, input int w);
        longint mx;
        mx = (longint'(1) <<< (w - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    // Decision score from the definition: sum of y*alpha*K with a clamped running sum, then bias.
    function automatic longint model_score(input int n, input logic mode, input int xt,
                                           input longint bs, input int w);
        longint acc;
        longint k;
        longint sgn;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            k   = longint'(xt) * longint'(b_x[i]) + 1;
            if (mode) k = k * k;
            sgn = (b_y[i] == 0) ? 0 : ((b_y[i] > 0) ? 1 : -1);
            acc = clamp(acc + sgn * longint'(b_alpha[i]) * k, w);
        end
        return clamp(acc + bs, w);
    endfunction

    task automatic fill(input int n, input int a, input int x, input int y);
        for (int i = 0; i < n; i++) begin
            b_alpha[i] = a;
            b_x[i]     = x;
            b_y[i]     = y;
        end
    endtask

    task automatic run(input string name, input int s, input int n, input logic mode,
                       input int xt, input longint bs, input bit gaps, input bit mid_start);
        int                 idx;
        int                 cyc;
        bit                 gap;
        bit                 rdy;
        bit                 pulsed;
        longint             e;
        logic signed [55:0] exp_s;
        logic signed [1:0]  exp_c;
        e     = model_score(n, mode, xt, bs, (s == 2) ? 16 : 56);
        exp_s = 56'(e);
        exp_c = (e > 0) ? 2'sb01 : 2'sb11;
        sel         = s;
        x_test      = 9'(xt);
        kernel_mode = mode;
        bias        = 56'(bs);
        start_v[s]  = 1'b1;
        @(posedge clk); #1;
        start_v = '0;
        n_checks++;
        if (busy_m !== 1'b1 || rdy_m !== 1'b1)
            $display("FAIL %s start: busy=%b sv_ready=%b, required 1/1", name, busy_m, rdy_m);
        else n_pass++;
        idx = 0;
        cyc = 0;
        pulsed = 0;
        while (idx < n && cyc < 200) begin
            gap      = gaps && ($urandom_range(0, 2) == 0);
            sv_valid = !gap;
            sv_alpha = 9'(b_alpha[idx]);
            sv_x     = 9'(b_x[idx]);
            sv_y     = 2'(b_y[idx]);
            if (mid_start && idx == 2 && !pulsed) begin
                start_v[s] = 1'b1;
                pulsed     = 1;
            end
            rdy = rdy_m;
            @(posedge clk); #1;
            start_v = '0;
            if (sv_valid && rdy) idx++;
            cyc++;
        end
        sv_valid = 1'b0;
        n_checks++;
        if (idx != n) $display("FAIL %s accepts: got %0d beats, required %0d", name, idx, n);
        else n_pass++;
        n_checks++;
        if (rdy_m !== 1'b0) $display("FAIL %s ready_after_last: sv_ready=%b, required 0", name, rdy_m);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (rv_m !== 1'b0) $display("FAIL %s early_result: result_valid=%b, required 0", name, rv_m);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (rv_m !== 1'b1 || sc_m !== exp_s || cls_m !== exp_c)
            $display("FAIL %s result: valid=%b score=%0d class=%0d, required 1 %0d %0d",
                     name, rv_m, sc_m, cls_m, exp_s, exp_c);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (rv_m !== 1'b0 || busy_m !== 1'b0 || sc_m !== exp_s || cls_m !== exp_c)
            $display("FAIL %s hold: valid=%b busy=%b score=%0d class=%0d, required 0 0 %0d %0d",
                     name, rv_m, busy_m, sc_m, cls_m, exp_s, exp_c);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        sel = 0;
        #1;
        n_checks++;
        if (rdy_m !== 1'b0 || busy_m !== 1'b0 || rv_m !== 1'b0 || cls_m !== 2'sb00 || sc_m !== 56'sd0)
            $display("FAIL reset: ready=%b busy=%b valid=%b class=%0d score=%0d, required all 0",
                     rdy_m, busy_m, rv_m, cls_m, sc_m);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy_m !== 1'b0 || rdy_m !== 1'b0)
            $display("FAIL idle_after_reset: busy=%b ready=%b, required 0 0", busy_m, rdy_m);
        else n_pass++;
    endtask

    task automatic test_kernels();
        fill(4, 1, 3, 1);
        run("poly2_pos", 0, 4, 1'b1, 2, 0, 0, 0);
        fill(4, 1, 3, -1);
        run("linear_neg", 0, 4, 1'b0, 2, 0, 0, 0);
    endtask

    task automatic test_balanced();
        fill(4, 5, 7, 1);
        b_y[2] = -1;
        b_y[3] = -2;
        run("balanced_b0", 0, 4, 1'b1, 3, 0, 0, 0);
        run("balanced_b1", 0, 4, 1'b1, 3, 1, 0, 0);
    endtask

    task automatic test_gaps();
        int z;
        fill(5, 1, 3, 1);
        z = $urandom_range(0, 4);
        b_y[z] = 0;
        b_alpha[z] = $urandom_range(0, 511);
        run("gaps_zero_label", 1, 5, 1'b1, 2, 0, 1, 0);
    endtask

    task automatic test_saturation();
        fill(4, 511, 511, 1);
        run("sat_pos", 2, 4, 1'b1, 511, 0, 0, 0);
        fill(4, 511, 511, -1);
        run("sat_neg", 2, 4, 1'b1, 511, 0, 0, 0);
    endtask

    task automatic test_reset_mid_run();
        sel = 0;
        fill(4, 9, 100, 1);
        start_v[0] = 1'b1;
        x_test = 9'd50;
        kernel_mode = 1'b1;
        bias = 56'sd0;
        @(posedge clk); #1;
        start_v = '0;
        sv_valid = 1'b1;
        sv_alpha = 9'd9;
        sv_x = 9'd100;
        sv_y = 2'sb01;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rdy_m !== 1'b0 || busy_m !== 1'b0 || rv_m !== 1'b0 || cls_m !== 2'sb00 || sc_m !== 56'sd0)
            $display("FAIL mid_reset: ready=%b busy=%b valid=%b class=%0d score=%0d, required all 0",
                     rdy_m, busy_m, rv_m, cls_m, sc_m);
        else n_pass++;
        sv_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        b_y[1] = -1;
        run("after_reset_restart_ignored", 0, 4, 1'b1, 50, -77, 0, 1);
    endtask

    task automatic test_random();
        int s;
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(0, 1);
            for (int i = 0; i < 5; i++) begin
                b_alpha[i] = $urandom_range(0, 511);
                b_x[i]     = $urandom_range(0, 511);
                b_y[i]     = $urandom_range(0, 3) - 2;
            end
            run("random", s, (s == 1) ? 5 : 4, 1'($urandom_range(0, 1)),
                $urandom_range(0, 511), longint'($urandom_range(0, 2000000)) - 1000000,
                1'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_kernels();
        test_balanced();
        test_reset_mid_run();
        test_gaps();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
